// File: rtl/vc_input_port.sv
// vc_input_port -- router input port with VC_NUM virtual channels.
//
// Each VC has its own flit FIFO and a small packet FSM (IDLE/REQ/ACTIVE).
// Head flits raise a round-robin route request toward the switch allocator.
// Granted VCs are then forwarded wormhole-style onto one shared output, with
// round-robin interleaving between VCs at flit granularity.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   data_in/vc_in/valid_in   upstream flit, its VC tag and valid
//   ready_in[VC_NUM]         per-VC "FIFO not full"
//   data_out/vc_out          selected flit and its VC (valid_out qualifies)
//   valid_out/ready_out      output handshake
//   route_req_valid/vc/dest  registered route request, held until route_grant
//   route_grant              single-cycle grant for route_req_vc
//   route_release/_vc        pulse on the handshake of a packet's last flit
//   flit_count, drop_count   only when VC_INPUT_PORT_STATS_EN is defined:
//                            output handshakes (wrapping) and malformed-flit
//                            discards (saturating)
//
// Flit type in flit[DATA_WIDTH-1 -: TYPE_WIDTH]:
//   00 HEAD_TAIL, 01 HEAD, 10 BODY, 11 TAIL.
// Destination of a head flit is in flit[DEST_WIDTH-1:0].
module vc_input_port #(
  parameter int DATA_WIDTH = 32,
  parameter int TYPE_WIDTH = 2,
  parameter int DEST_WIDTH = 4,
  parameter int VC_NUM     = 4,
  parameter int VC_WIDTH   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [VC_WIDTH-1:0]   vc_in,
  input  logic                  valid_in,
  output logic [VC_NUM-1:0]     ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [VC_WIDTH-1:0]   vc_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  route_req_valid,
  output logic [VC_WIDTH-1:0]   route_req_vc,
  output logic [DEST_WIDTH-1:0] route_req_dest,
  input  logic                  route_grant,
  output logic                  route_release,
  output logic [VC_WIDTH-1:0]   route_release_vc
`ifdef VC_INPUT_PORT_STATS_EN
  ,
  output logic [31:0]           flit_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [TYPE_WIDTH-1:0] T_HT   = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(3);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;

  localparam logic [VC_WIDTH-1:0] VC_LAST  = VC_WIDTH'(VC_NUM - 1);
  localparam logic [VC_WIDTH:0]   VC_NUM_W = (VC_WIDTH + 1)'(VC_NUM);

  // Next VC index with wrap at VC_NUM (VC_NUM need not be a power of 2).
  function automatic logic [VC_WIDTH-1:0] nxt(input logic [VC_WIDTH-1:0] x);
    return (x == VC_LAST) ? '0 : x + VC_WIDTH'(1);
  endfunction

  // Round-robin pick: first set bit of cand at or after base.
  // Returns {found, index}.
  function automatic logic [VC_WIDTH:0] rr_pick(input logic [VC_NUM-1:0]   cand,
                                                input logic [VC_WIDTH-1:0] base);
    logic [2*VC_NUM-1:0] dbl;
    logic [VC_WIDTH:0]   sum;
    logic [VC_WIDTH:0]   r;
    dbl = {cand, cand} >> base;
    r   = '0;
    sum = '0;
    // Scan far-to-near so the nearest candidate is the one that sticks.
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        sum = {1'b0, base} + (VC_WIDTH + 1)'(i);
        if (sum >= VC_NUM_W) sum = sum - VC_NUM_W;
        r = {1'b1, sum[VC_WIDTH-1:0]};
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-VC view shared between the VC slices and the arbiters
  // ---------------------------------------------------------------------------
  logic [VC_NUM-1:0][DATA_WIDTH-1:0] front;
  logic [VC_NUM-1:0] empty, full, push, pop, discard;
  logic [VC_NUM-1:0] is_req, eligible, grant_vc, hs_vc, tail_front;

  // Request arbiter state
  logic                  req_valid_q, req_valid_d;
  logic [VC_WIDTH-1:0]   req_vc_q, req_vc_d;
  logic [DEST_WIDTH-1:0] req_dest_q, req_dest_d;
  logic [VC_WIDTH-1:0]   rr_req_q, rr_req_d;
  logic [VC_WIDTH-1:0]   req_base;
  logic [VC_WIDTH:0]     req_pick;
  logic                  grant_acc;

  // Output arbiter state
  logic                  lock_q;
  logic [VC_WIDTH-1:0]   lock_vc_q;
  logic [VC_WIDTH-1:0]   out_rr_q;
  logic [VC_WIDTH:0]     out_pick;
  logic [VC_WIDTH-1:0]   sel;
  logic                  hs;

  assign grant_acc = route_grant && req_valid_q;
  assign ready_in  = ~full;

  // ---------------------------------------------------------------------------
  // VC slices: FIFO + packet FSM
  // ---------------------------------------------------------------------------
  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_q, rd_q;
    logic [1:0]            st_q, st_d;
    logic [TYPE_WIDTH-1:0] ty;
    logic                  is_head;

    assign empty[v]      = (wr_q == rd_q);
    assign full[v]       = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign front[v]      = mem_q[rd_q[AW-1:0]];
    assign ty            = front[v][DATA_WIDTH-1 -: TYPE_WIDTH];
    assign is_head       = (ty == T_HT) || (ty == T_HEAD);
    assign tail_front[v] = (ty == T_HT) || (ty == T_TAIL);

    assign push[v]     = valid_in && (vc_in == VC_WIDTH'(v)) && !full[v];
    // A BODY/TAIL reaching the front of an idle VC has no head: drop it.
    assign discard[v]  = (st_q == ST_IDLE) && !empty[v] && !is_head;
    assign grant_vc[v] = grant_acc && (req_vc_q == VC_WIDTH'(v));
    assign hs_vc[v]    = hs && (sel == VC_WIDTH'(v));
    assign pop[v]      = discard[v] || hs_vc[v];
    assign eligible[v] = (st_q == ST_ACT) && !empty[v];
    // Entering REQ already makes the VC a request candidate, so the
    // registered request appears the cycle after the head becomes visible.
    assign is_req[v]   = (st_d == ST_REQ);

    always_comb begin
      st_d = st_q;
      case (st_q)
        ST_IDLE: if (!empty[v] && is_head)      st_d = ST_REQ;
        ST_REQ:  if (grant_vc[v])               st_d = ST_ACT;
        ST_ACT:  if (hs_vc[v] && tail_front[v]) st_d = ST_IDLE;
        default:                                st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_q <= '0;
        rd_q <= '0;
        st_q <= ST_IDLE;
      end else begin
        if (push[v]) wr_q <= wr_q + PW'(1);
        if (pop[v])  rd_q <= rd_q + PW'(1);
        st_q <= st_d;
      end
    end

    // Storage is not reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (push[v]) mem_q[wr_q[AW-1:0]] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Route request arbitration (one outstanding request)
  // ---------------------------------------------------------------------------
  always_comb begin
    // On a grant the next request may be chosen in the same cycle, searching
    // from the VC after the one just granted (it has left REQ via st_d).
    req_base    = grant_acc ? nxt(req_vc_q) : rr_req_q;
    req_pick    = rr_pick(is_req, req_base);
    req_valid_d = req_valid_q;
    req_vc_d    = req_vc_q;
    req_dest_d  = req_dest_q;
    rr_req_d    = rr_req_q;
    if (grant_acc) begin
      rr_req_d    = nxt(req_vc_q);
      req_valid_d = 1'b0;
    end
    if ((!req_valid_q || grant_acc) && req_pick[VC_WIDTH]) begin
      req_valid_d = 1'b1;
      req_vc_d    = req_pick[VC_WIDTH-1:0];
      req_dest_d  = front[req_pick[VC_WIDTH-1:0]][DEST_WIDTH-1:0];
    end
  end

  assign route_req_valid = req_valid_q;
  assign route_req_vc    = req_vc_q;
  assign route_req_dest  = req_dest_q;

  // ---------------------------------------------------------------------------
  // Output arbitration
  // ---------------------------------------------------------------------------
  // While stalled, the offered VC stays locked so data_out is stable even if
  // another VC with better round-robin priority becomes eligible.
  assign out_pick  = rr_pick(eligible, out_rr_q);
  assign sel       = lock_q ? lock_vc_q : out_pick[VC_WIDTH-1:0];
  assign valid_out = lock_q || out_pick[VC_WIDTH];
  assign hs        = valid_out && ready_out;

  assign data_out         = valid_out ? front[sel] : '0;
  assign vc_out           = valid_out ? sel : '0;
  assign route_release    = hs && tail_front[sel];
  assign route_release_vc = route_release ? sel : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid_q <= 1'b0;
      req_vc_q    <= '0;
      req_dest_q  <= '0;
      rr_req_q    <= '0;
      lock_q      <= 1'b0;
      lock_vc_q   <= '0;
      out_rr_q    <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_vc_q    <= req_vc_d;
      req_dest_q  <= req_dest_d;
      rr_req_q    <= rr_req_d;
      if (hs) begin
        out_rr_q <= nxt(sel);
        lock_q   <= 1'b0;
      end else if (valid_out) begin
        lock_q    <= 1'b1;
        lock_vc_q <= sel;
      end
    end
  end

`ifdef VC_INPUT_PORT_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [31:0] flit_cnt_q;
  logic [15:0] drop_cnt_q;
  logic [3:0]  ndrop;
  logic [16:0] drop_sum;

  // Several idle VCs may discard in the same cycle.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < VC_NUM; i++) ndrop = ndrop + 4'(discard[i]);
    drop_sum = {1'b0, drop_cnt_q} + 17'(ndrop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      flit_cnt_q <= flit_cnt_q + 32'(hs);
      drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign flit_count = flit_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vc_input_port.sv
module tb_vc_input_port;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic [1:0]  vc_in = '0;
  logic        valid_in = 1'b0;
  logic [3:0]  ready_in;
  logic [31:0] data_out;
  logic [1:0]  vc_out;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic        route_req_valid;
  logic [1:0]  route_req_vc;
  logic [3:0]  route_req_dest;
  logic        route_grant = 1'b0;
  logic        route_release;
  logic [1:0]  route_release_vc;
`ifdef VC_INPUT_PORT_STATS_EN
  logic [31:0] flit_count;
  logic [15:0] drop_count;
`endif

  vc_input_port dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .vc_in(vc_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .vc_out(vc_out), .valid_out(valid_out), .ready_out(ready_out),
    .route_req_valid(route_req_valid), .route_req_vc(route_req_vc),
    .route_req_dest(route_req_dest), .route_grant(route_grant),
    .route_release(route_release), .route_release_vc(route_release_vc)
`ifdef VC_INPUT_PORT_STATS_EN
    , .flit_count(flit_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit auto_gnt = 1'b0;
  logic [1:0] gq_vc[$];
  logic [3:0] gq_dest[$];

  typedef struct {
    logic vin; logic [1:0] vc; logic [31:0] din; logic rdy; logic gnt;
    logic e_vo; logic [1:0] e_vc; logic [31:0] e_do;
    logic e_rv; logic [1:0] e_rvc; logic [3:0] e_rd;
    logic e_rel; logic [1:0] e_relvc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are then sampled
  // 1 time unit later, well before the next rising edge.
  task automatic step(input logic vin, input logic [1:0] vc, input logic [31:0] d,
                      input logic rdy, input logic gnt);
    @(negedge clk);
    valid_in = vin; vc_in = vc; data_in = d; ready_out = rdy; route_grant = gnt;
    #1;
    if (auto_gnt) route_grant = route_req_valid;
    if (route_grant && route_req_valid) begin
      gq_vc.push_back(route_req_vc);
      gq_dest.push_back(route_req_dest);
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'd0, 32'h0, rdy, 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0; ready_out = 1'b0; route_grant = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    auto_gnt = 1'b0;
    gq_vc.delete(); gq_dest.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    logic [31:0] fl[8];
    logic [31:0] ed[9];
    logic [1:0]  ev[9];
    int k;

    // ---------------- reset state ----------------
    reset_dut();
    idle(1'b0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_vc_out", vc_out, 0);
    chk("rst_req_valid", route_req_valid, 0);
    chk("rst_req_vc", route_req_vc, 0);
    chk("rst_req_dest", route_req_dest, 0);
    chk("rst_release", route_release, 0);
    chk("rst_release_vc", route_release_vc, 0);
    chk("rst_ready_in", ready_in, 4'hF);
`ifdef VC_INPUT_PORT_STATS_EN
    chk("rst_flit_count", flit_count, 0);
    chk("rst_drop_count", drop_count, 0);
`endif

    // ---------------- 4-flit packet on VC2, table driven ----------------
    //          vin vc   din            rdy gnt  vo vc   do            rv rvc rd  rel rvc
    vt[0] = '{1, 2'd2, 32'h4000_0005, 1, 0,  0, 2'd0, 32'h0,         0, 2'd0, 4'd0, 0, 2'd0};
    vt[1] = '{1, 2'd2, 32'h8000_0011, 1, 0,  0, 2'd0, 32'h0,         0, 2'd0, 4'd0, 0, 2'd0};
    vt[2] = '{1, 2'd2, 32'h8000_0022, 1, 1,  0, 2'd0, 32'h0,         1, 2'd2, 4'd5, 0, 2'd0};
    vt[3] = '{1, 2'd2, 32'hC000_0033, 1, 0,  1, 2'd2, 32'h4000_0005, 0, 2'd0, 4'd0, 0, 2'd0};
    vt[4] = '{0, 2'd0, 32'h0,         1, 0,  1, 2'd2, 32'h8000_0011, 0, 2'd0, 4'd0, 0, 2'd0};
    vt[5] = '{0, 2'd0, 32'h0,         1, 0,  1, 2'd2, 32'h8000_0022, 0, 2'd0, 4'd0, 0, 2'd0};
    vt[6] = '{0, 2'd0, 32'h0,         1, 0,  1, 2'd2, 32'hC000_0033, 0, 2'd0, 4'd0, 1, 2'd2};
    vt[7] = '{0, 2'd0, 32'h0,         1, 0,  0, 2'd0, 32'h0,         0, 2'd0, 4'd0, 0, 2'd0};
    for (int i = 0; i < 8; i++) begin
      step(vt[i].vin, vt[i].vc, vt[i].din, vt[i].rdy, vt[i].gnt);
      chk($sformatf("t1_v%0d_valid_out", i), valid_out, vt[i].e_vo);
      if (vt[i].e_vo) begin
        chk($sformatf("t1_v%0d_vc_out", i), vc_out, vt[i].e_vc);
        chk($sformatf("t1_v%0d_data_out", i), data_out, vt[i].e_do);
      end
      chk($sformatf("t1_v%0d_req_valid", i), route_req_valid, vt[i].e_rv);
      if (vt[i].e_rv) begin
        chk($sformatf("t1_v%0d_req_vc", i), route_req_vc, vt[i].e_rvc);
        chk($sformatf("t1_v%0d_req_dest", i), route_req_dest, vt[i].e_rd);
      end
      chk($sformatf("t1_v%0d_release", i), route_release, vt[i].e_rel);
      if (vt[i].e_rel) chk($sformatf("t1_v%0d_release_vc", i), route_release_vc, vt[i].e_relvc);
      chk($sformatf("t1_v%0d_ready_in", i), ready_in, 4'hF);
    end
`ifdef VC_INPUT_PORT_STATS_EN
    chk("t1_flit_count", flit_count, 4);
`endif

    // ---------------- fill VC0, full, one pop ----------------
    reset_dut();
    fl[0] = 32'h4000_0003;
    for (int i = 1; i < 8; i++) fl[i] = 32'h8000_0000 | 32'(i);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, fl[i], 1'b0, 1'b0);
      chk($sformatf("t2_fill%0d_ready0", i), ready_in[0], 1'b1);
    end
    // This push is refused: VC0 is full.
    step(1'b1, 2'd0, 32'hC000_0BAD, 1'b0, 1'b0);
    chk("t2_full_ready_in", ready_in, 4'b1110);
    step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    chk("t2_req_valid", route_req_valid, 1'b1);
    chk("t2_req_vc", route_req_vc, 0);
    chk("t2_req_dest", route_req_dest, 3);
    idle(1'b1);
    chk("t2_head_out", data_out, fl[0]);
    chk("t2_pop_ready_in", ready_in, 4'b1110);
    for (int i = 1; i < 8; i++) begin
      idle(1'b1);
      if (i == 1) chk("t2_after_pop_ready_in", ready_in, 4'hF);
      chk($sformatf("t2_drain%0d", i), data_out, fl[i]);
    end
    idle(1'b0);
    chk("t2_refused_not_stored", valid_out, 1'b0);

    // ---------------- VC0/VC1/VC3 requests and interleave ----------------
    reset_dut();
    auto_gnt = 1'b1;
    ed = '{32'h4000_000A, 32'h4000_000B, 32'h4000_000C,
           32'h8000_0100, 32'h8000_0101, 32'h8000_0103,
           32'hC000_0200, 32'hC000_0201, 32'hC000_0203};
    ev = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 9; i++) step(1'b1, ev[i], ed[i], 1'b0, 1'b0);
    k = 0;
    while (gq_vc.size() < 3 && k < 20) begin idle(1'b0); k++; end
    chk("t3_grant_count", gq_vc.size(), 3);
    if (gq_vc.size() == 3) begin
      chk("t3_req0_vc", gq_vc[0], 0);
      chk("t3_req1_vc", gq_vc[1], 1);
      chk("t3_req2_vc", gq_vc[2], 3);
      chk("t3_req2_dest", gq_dest[2], 4'hC);
    end
    for (int i = 0; i < 9; i++) begin
      idle(1'b1);
      chk($sformatf("t3_out%0d_valid", i), valid_out, 1'b1);
      chk($sformatf("t3_out%0d_vc", i), vc_out, ev[i]);
      chk($sformatf("t3_out%0d_data", i), data_out, ed[i]);
      chk($sformatf("t3_out%0d_release", i), route_release, (i >= 6));
    end

    // ---------------- malformed BODY on idle VC1 ----------------
    reset_dut();
    auto_gnt = 1'b1;
    step(1'b1, 2'd1, 32'h8000_0777, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk($sformatf("t4_no_req%0d", i), route_req_valid, 1'b0);
      chk($sformatf("t4_no_out%0d", i), valid_out, 1'b0);
    end
`ifdef VC_INPUT_PORT_STATS_EN
    chk("t4_drop_count", drop_count, 1);
`endif
    step(1'b1, 2'd1, 32'h0000_1239, 1'b1, 1'b0);
    k = 0;
    do begin idle(1'b1); k++; end while (!valid_out && k < 20);
    chk("t4_out_seen", valid_out, 1'b1);
    chk("t4_req_vc", (gq_vc.size() > 0) ? gq_vc[0] : 2'd2, 1);
    chk("t4_req_dest", (gq_dest.size() > 0) ? gq_dest[0] : 4'd0, 9);
    chk("t4_data", data_out, 32'h0000_1239);
    chk("t4_release", route_release, 1'b1);
    chk("t4_release_vc", route_release_vc, 1);

    // ---------------- stall with VC2 and VC0 eligible ----------------
    reset_dut();
    auto_gnt = 1'b1;
    step(1'b1, 2'd2, 32'h4000_0001, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'h4000_0002, 1'b0, 1'b0);
    step(1'b1, 2'd2, 32'hC000_0022, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'hC000_0020, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk($sformatf("t5_hold%0d_valid", i), valid_out, 1'b1);
      chk($sformatf("t5_hold%0d_vc", i), vc_out, 2);
      chk($sformatf("t5_hold%0d_data", i), data_out, 32'h4000_0001);
    end
    idle(1'b1);
    chk("t5_hs_vc", vc_out, 2);
    chk("t5_hs_data", data_out, 32'h4000_0001);
    idle(1'b1);
    chk("t5_next_vc", vc_out, 0);
    chk("t5_next_data", data_out, 32'h4000_0002);
    idle(1'b1);
    chk("t5_tail2_data", data_out, 32'hC000_0022);
    chk("t5_tail2_release_vc", {route_release, route_release_vc}, 3'b110);
    idle(1'b1);
    chk("t5_tail0_data", data_out, 32'hC000_0020);
    chk("t5_tail0_release_vc", {route_release, route_release_vc}, 3'b100);

    // ---------------- async reset mid-packet on VC1 ----------------
    reset_dut();
    auto_gnt = 1'b1;
    step(1'b1, 2'd1, 32'h4000_0001, 1'b0, 1'b0);
    step(1'b1, 2'd1, 32'h8000_0101, 1'b0, 1'b0);
    idle(1'b0);
    auto_gnt = 1'b0;
    step(1'b1, 2'd3, 32'h4000_0004, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("t6_pre_valid_out", valid_out, 1'b1);
    chk("t6_pre_vc_out", vc_out, 1);
    chk("t6_pre_req_valid", route_req_valid, 1'b1);
    chk("t6_pre_req_vc", route_req_vc, 3);
    #2 rst = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("t6_rst_valid_out", valid_out, 1'b0);
    chk("t6_rst_data_out", data_out, 0);
    chk("t6_rst_vc_out", vc_out, 0);
    chk("t6_rst_req_valid", route_req_valid, 1'b0);
    chk("t6_rst_req_vc", route_req_vc, 0);
    chk("t6_rst_ready_in", ready_in, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    gq_vc.delete(); gq_dest.delete();
    auto_gnt = 1'b1;
    step(1'b1, 2'd1, 32'h4000_0007, 1'b0, 1'b0);
    k = 0;
    do begin idle(1'b0); k++; end while (!valid_out && k < 20);
    chk("t6_new_out_seen", valid_out, 1'b1);
    chk("t6_new_grants", gq_vc.size(), 1);
    chk("t6_new_req_vc", (gq_vc.size() > 0) ? gq_vc[0] : 2'd3, 1);
    chk("t6_new_req_dest", (gq_dest.size() > 0) ? gq_dest[0] : 4'd0, 7);
    chk("t6_new_vc_out", vc_out, 1);
    chk("t6_new_data", data_out, 32'h4000_0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
